// File: rtl/uart_pkg.sv
// Shared types for the serial receive path: receiver FSM states and byte width.
// Pure declarations; no logic, no latency, no flow control.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/sync_ff.sv
// N-flop synchronizer for an asynchronous single-bit input; resets to 1 (idle line).
// Latency N cycles; no backpressure, samples every clock.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages;

  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= '1;
    end else begin
      stages <= {stages[N-2:0], d};
    end
  end

  assign q = stages[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver: byte plus one-cycle data_valid, framing_err on a low stop bit.
// data_valid follows the mid-stop sample by one cycle; no backpressure, consumer captures on the pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] uart_data,
  output logic                      data_valid,
  output logic                      framing_err,
  output logic                      busy
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_MAX = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  uart_rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]          clk_cnt, clk_cnt_nxt;
  logic [2:0]                bit_cnt, bit_cnt_nxt;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_nxt;
  logic [UART_DATA_BITS-1:0] data_nxt;
  logic                      dv_nxt, fe_nxt;

  sync_ff #(.N(SYNC_STAGES)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      uart_data   <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      clk_cnt     <= clk_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shift_reg   <= shift_nxt;
      uart_data   <= data_nxt;
      data_valid  <= dv_nxt;
      framing_err <= fe_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    data_nxt    = uart_data;
    dv_nxt      = 1'b0;
    fe_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt   = START;
          clk_cnt_nxt = '0;
        end
      end

      // Half a bit in, a high line means the falling edge was only a glitch.
      START: begin
        if (clk_cnt == HALF_MAX) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            clk_cnt_nxt = '0;
            bit_cnt_nxt = '0;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (clk_cnt == FULL_MAX) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {rx_s, shift_reg[UART_DATA_BITS-1:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = STOP;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_ONE;
        end
      end

      // Leaving at mid stop bit lets a back-to-back start bit be caught.
      STOP: begin
        if (clk_cnt == FULL_MAX) begin
          clk_cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shift_reg;
            dv_nxt    = 1'b1;
            state_nxt = IDLE;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_ONE;
        end
      end

      // A held-low line reports once, then waits for the line to go idle.
      BREAK: begin
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences, random frames
// scored against a sample-point model of the line waveform.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] uart_data;
  logic       data_valid;
  logic       framing_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .uart_data   (uart_data),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  int errors = 0;
  int checks = 0;

  // Event log: {1'b0, byte} for data_valid, 9'h100 for framing_err.
  int         cyc = 0;
  logic [8:0] ev_q[$];
  int         ev_t[$];
  int         rule_viol = 0;
  logic       dv_prev = 1'b0;
  logic       fe_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (data_valid) begin
      ev_q.push_back({1'b0, uart_data});
      ev_t.push_back(cyc);
    end
    if (framing_err) begin
      ev_q.push_back(9'h100);
      ev_t.push_back(cyc);
    end
    if ((data_valid && framing_err) || (data_valid && dv_prev) || (framing_err && fe_prev))
      rule_viol++;
    dv_prev = data_valid;
    fe_prev = framing_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int ctx, input logic stop);
    rx = 1'b0;
    tick(ctx);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(ctx);
    end
    rx = stop;
    tick(ctx);
  endtask

  task automatic expect_one_ev(input string name, input logic [8:0] exp);
    check({name, "_count"}, ev_q.size(), 1);
    if (ev_q.size() > 0) check({name, "_event"}, ev_q.pop_front(), exp);
  endtask

  // Line level at a given cycle offset from the start edge, for a transmitter at ctx clocks/bit.
  function automatic logic line_at(input logic [7:0] b, input int ctx, input int o);
    int idx;
    idx = o / ctx;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // The receiver samples mid-bit of its own bit grid: offset CPB/2 + CPB*k after the start edge.
  function automatic logic [8:0] model_frame(input logic [7:0] b, input int ctx);
    logic [7:0] d;
    for (int k = 1; k <= 8; k++) d[k-1] = line_at(b, ctx, CPB / 2 + CPB * k);
    if (line_at(b, ctx, CPB / 2 + CPB * 9)) return {1'b0, d};
    return 9'h100;
  endfunction

  typedef struct {
    logic [7:0] dat;
    int         ctx;
    logic       stop;
    logic [8:0] exp_ev;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  vec_t       tbl[4];
  logic [7:0] last_good;
  logic [7:0] rb;
  logic [8:0] rexp;
  int         rctx;
  int         t0;
  int         lat;

  initial begin
    tbl[0] = '{8'hA5, 16, 1'b1, 9'h0A5, 8'hA5, 1'b0};
    tbl[1] = '{8'hC3, 15, 1'b1, 9'h0C3, 8'hC3, 1'b0};
    tbl[2] = '{8'h5E, 16, 1'b1, 9'h05E, 8'h5E, 1'b0};
    tbl[3] = '{8'hC3, 17, 1'b1, 9'h0C3, 8'hC3, 1'b0};

    reset = 1'b1;
    rx    = 1'b1;
    tick(3);
    check("rst_uart_data", uart_data, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_framing_err", framing_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick(CPB);

    foreach (tbl[i]) begin
      ev_q.delete();
      send(tbl[i].dat, tbl[i].ctx, tbl[i].stop);
      rx = 1'b1;
      tick(3 * CPB);
      expect_one_ev($sformatf("vec%0d", i), tbl[i].exp_ev);
      check($sformatf("vec%0d_data", i), uart_data, tbl[i].exp_data);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
    end

    // Back-to-back frames, no idle gap.
    ev_q.delete();
    ev_t.delete();
    t0 = cyc;
    send(8'h00, CPB, 1'b1);
    send(8'hFF, CPB, 1'b1);
    tick(2 * CPB);
    check("b2b_count", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      check("b2b_first", ev_q[0], 9'h000);
      check("b2b_second", ev_q[1], 9'h0FF);
      check("b2b_spacing", ev_t[1] - ev_t[0], 160);
      lat = ev_t[0] - t0;
      check("b2b_latency_window", (lat >= 152 && lat <= 160), 1'b1);
    end
    check("b2b_data", uart_data, 8'hFF);
    last_good = 8'hFF;

    // Short low glitch while idle.
    ev_q.delete();
    rx = 1'b0;
    tick(4);
    check("glitch_busy_high", busy, 1'b1);
    rx = 1'b1;
    tick(2 * CPB);
    check("glitch_no_pulse", ev_q.size(), 0);
    check("glitch_data", uart_data, last_good);
    check("glitch_busy_low", busy, 1'b0);

    // Low stop bit, line held low for 40 bit times, then a good frame.
    ev_q.delete();
    send(8'h3C, CPB, 1'b0);
    tick(40 * CPB);
    check("break_busy_held", busy, 1'b1);
    rx = 1'b1;
    tick(CPB);
    check("break_busy_released", busy, 1'b0);
    expect_one_ev("break", 9'h100);
    check("break_data_kept", uart_data, last_good);
    ev_q.delete();
    send(8'h81, CPB, 1'b1);
    tick(2 * CPB);
    expect_one_ev("after_break", 9'h081);
    check("after_break_data", uart_data, 8'h81);

    // Reset during data bit 4 of a frame.
    ev_q.delete();
    rb = 8'h5A;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      tick(CPB);
    end
    rx = rb[4];
    tick(4);
    check("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    rx    = 1'b1;
    tick(3);
    check("abort_uart_data", uart_data, 8'h00);
    check("abort_data_valid", data_valid, 1'b0);
    check("abort_framing_err", framing_err, 1'b0);
    check("abort_busy", busy, 1'b0);
    reset = 1'b0;
    tick(2 * CPB);
    check("abort_no_pulse", ev_q.size(), 0);
    send(8'h12, CPB, 1'b1);
    tick(2 * CPB);
    expect_one_ev("after_abort", 9'h012);
    check("after_abort_data", uart_data, 8'h12);
    last_good = 8'h12;

    // Random frames at nominal and skewed transmitter rates.
    for (int n = 0; n < 40; n++) begin
      rb   = 8'($urandom_range(0, 255));
      rctx = 15 + int'($urandom_range(0, 2));
      rexp = model_frame(rb, rctx);
      ev_q.delete();
      send(rb, rctx, 1'b1);
      if (rctx == CPB) tick(int'($urandom_range(0, 20)));
      else tick(int'($urandom_range(40, 60)));
      expect_one_ev($sformatf("rand%0d_b%02h_c%0d", n, rb, rctx), rexp);
      if (!rexp[8]) last_good = rexp[7:0];
    end
    tick(2 * CPB);
    check("rand_final_data", uart_data, last_good);
    check("rand_final_busy", busy, 1'b0);

    check("pulse_rules", rule_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
